// File: rtl/life_meter.sv
// life_meter: DDR-style life meter placed between the per-lane judge blocks
// and the VGA pixel mux.
//
// Each cycle the judged lanes are folded into a life delta and a combo
// update. A small IDLE/PLAY/FAILED state machine gates both. A vertical life
// bar is drawn from a per-frame snapshot of the life value, so the bar never
// tears in the middle of a frame.
//
// Optional feature: define LIFE_METER_FLASH_EN to make the bar flash while in
// PLAY with the displayed life below DANGER_LVL. The bar blanks on alternate
// FLASH_FRAMES-frame phases. Without the macro no frame counter is built.
//
// Ports:
//   clk_i       pixel clock
//   rst_i       asynchronous reset, active-high
//   start_i     1-cycle pulse: begin or restart a song
//   frame_i     1-cycle pulse at end of active frame
//   sx_i, sy_i  current pixel coordinates
//   judge_i     per lane {mv,pf,gr,gd}; lane n is bits [4n+3:4n]
//   miss_i      per-lane miss pulse
//   life_o      live life value
//   combo_o     current combo (saturating)
//   failed_o    high while in FAILED
//   full_o      life_o == MAX_LIFE
//   life_bar_o  bar pixel lit (registered, 1 cycle after sx_i/sy_i)
module life_meter #(
    parameter int CORDW        = 10,
    parameter int LANES        = 4,
    parameter int MAX_LIFE     = 300,
    parameter int START_LIFE   = 150,
    parameter int GAIN_MV      = 12,
    parameter int GAIN_PF      = 9,
    parameter int GAIN_GR      = 6,
    parameter int GAIN_GD      = 3,
    parameter int MISS_PEN     = 20,
    parameter int BAR_X0       = 170,
    parameter int BAR_Y_BASE   = 390,
    parameter int DANGER_LVL   = 60,
    parameter int FLASH_FRAMES = 8,
    localparam int LW          = $clog2(MAX_LIFE + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               frame_i,
    input  logic [CORDW-1:0]   sx_i,
    input  logic [CORDW-1:0]   sy_i,
    input  logic [4*LANES-1:0] judge_i,
    input  logic [LANES-1:0]   miss_i,
    output logic [LW-1:0]      life_o,
    output logic [15:0]        combo_o,
    output logic               failed_o,
    output logic               full_o,
    output logic               life_bar_o
);

    localparam int DW = LW + 8;

    typedef enum logic [1:0] {IDLE, PLAY, FAILED} state_t;

    state_t state, state_nx;

    logic [LW-1:0]        life_nx, life_sat, disp;
    logic [15:0]          combo_nx, combo_inc;
    logic [16:0]          combo_sum;
    logic [7:0]           hit_cnt;
    logic                 any_miss;
    logic [3:0]           lane;
    logic signed [DW-1:0] gain_sum, pen_sum, life_sum;
    logic                 in_x, in_y, blank, bar_nx;
    logic [CORDW:0]       sy_plus;

    function automatic logic [LW-1:0] sat_life(input logic signed [DW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > DW'(MAX_LIFE))
            return LW'(MAX_LIFE);
        else
            return v[LW-1:0];
    endfunction

    // Lane decode: highest grade bit wins; a lane with any grade bit is a hit
    // and its miss bit is ignored.
    always_comb begin
        gain_sum = '0;
        pen_sum  = '0;
        hit_cnt  = '0;
        any_miss = 1'b0;
        lane     = '0;
        for (int n = 0; n < LANES; n++) begin
            lane = judge_i[4*n +: 4];
            if (lane[3])      gain_sum = gain_sum + DW'(GAIN_MV);
            else if (lane[2]) gain_sum = gain_sum + DW'(GAIN_PF);
            else if (lane[1]) gain_sum = gain_sum + DW'(GAIN_GR);
            else if (lane[0]) gain_sum = gain_sum + DW'(GAIN_GD);
            if (lane != 4'b0000) begin
                hit_cnt = hit_cnt + 8'd1;
            end else if (miss_i[n]) begin
                any_miss = 1'b1;
                pen_sum  = pen_sum + DW'(MISS_PEN);
            end
        end
        life_sum  = $signed({{(DW-LW){1'b0}}, life_o}) + gain_sum - pen_sum;
        life_sat  = sat_life(life_sum);
        combo_sum = {1'b0, combo_o} + 17'(hit_cnt);
        combo_inc = combo_sum[16] ? 16'hFFFF : combo_sum[15:0];
    end

    // Next-state logic; start_i overrides every other input in every state.
    always_comb begin
        state_nx = state;
        life_nx  = life_o;
        combo_nx = combo_o;
        if (start_i) begin
            state_nx = PLAY;
            life_nx  = LW'(START_LIFE);
            combo_nx = '0;
        end else begin
            case (state)
                IDLE: ;
                PLAY: begin
                    life_nx  = life_sat;
                    combo_nx = any_miss ? 16'd0 : combo_inc;
                    if (life_sat == '0)
                        state_nx = FAILED;
                end
                FAILED: life_nx = '0;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            life_o  <= LW'(START_LIFE);
            combo_o <= '0;
        end else begin
            state   <= state_nx;
            life_o  <= life_nx;
            combo_o <= combo_nx;
        end
    end

    assign failed_o = (state == FAILED);
    assign full_o   = (life_o == LW'(MAX_LIFE));

`ifdef LIFE_METER_FLASH_EN
    localparam int FW = $clog2(2 * FLASH_FRAMES);

    logic [FW-1:0] fcnt;
    logic          danger;

    assign danger = (state == PLAY) && (disp < LW'(DANGER_LVL));

    // Frame counter runs only inside the danger zone; it wraps over one
    // full on/off flash period.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            fcnt <= '0;
        else if (start_i || !danger)
            fcnt <= '0;
        else if (frame_i)
            fcnt <= (fcnt == FW'(2 * FLASH_FRAMES - 1)) ? '0 : fcnt + 1'b1;
    end

    assign blank = danger && (fcnt >= FW'(FLASH_FRAMES));
`else
    assign blank = 1'b0;
`endif

    // Bar spans rows BAR_Y_BASE-disp..BAR_Y_BASE; the test is written as
    // sy+disp >= BAR_Y_BASE so no subtraction can underflow.
    always_comb begin
        in_x    = (sx_i >= CORDW'(BAR_X0)) && (sx_i <= CORDW'(BAR_X0 + 15));
        sy_plus = {1'b0, sy_i} + (CORDW+1)'(disp);
        in_y    = (sy_i <= CORDW'(BAR_Y_BASE)) &&
                  (sy_plus >= (CORDW+1)'(BAR_Y_BASE));
        bar_nx  = in_x && in_y && (state != FAILED) && !blank;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            disp       <= LW'(START_LIFE);
            life_bar_o <= 1'b0;
        end else begin
            if (frame_i)
                disp <= life_o;
            life_bar_o <= bar_nx;
        end
    end

endmodule
